mod_exp: RTL



---
 rtl/mod_arith_pkg.sv | 20 ++
 rtl/mod_mul.sv | 31 +++
 rtl/mod_exp.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mod_arith_pkg.sv
// rtl/mod_arith_pkg.sv - shared modulus constants and exponentiator state encoding
package mod_arith_pkg;

  localparam int unsigned MOD_DEFAULT    = 32'd998244353;
  localparam int unsigned NPRIME_DEFAULT = 32'd998244351;
  localparam int unsigned R2MOD_DEFAULT  = 32'd932051910;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    LOAD = S_LOAD,
    RUN  = S_RUN,
    DONE = S_DONE
  } exp_state_t;

endpackage

// File: rtl/mod_mul.sv
// rtl/mod_mul.sv - combinational modular multiply a*b mod MOD via two Montgomery reductions
// First REDC gives a*b*R^-1, second REDC against R^2 mod MOD restores the plain product.
module mod_mul #(
  parameter int unsigned WIDTH  = 32,
  parameter logic [WIDTH-1:0] MOD    = WIDTH'(mod_arith_pkg::MOD_DEFAULT),
  parameter logic [WIDTH-1:0] NPRIME = WIDTH'(mod_arith_pkg::NPRIME_DEFAULT),
  parameter logic [WIDTH-1:0] R2MOD  = WIDTH'(mod_arith_pkg::R2MOD_DEFAULT)
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_p
);

  // Valid for any t < MOD*2^WIDTH, which covers (any base)*1 and (x<MOD)*(y<MOD).
  function automatic logic [WIDTH-1:0] redc(input logic [2*WIDTH-1:0] t);
    logic [WIDTH-1:0] m;
    logic [2*WIDTH:0] s;
    logic [WIDTH:0]   u;
    m = t[WIDTH-1:0] * NPRIME;
    s = {1'b0, t} + ({{(WIDTH+1){1'b0}}, m} * {{(WIDTH+1){1'b0}}, MOD});
    u = (WIDTH+1)'(s >> WIDTH);
    if (u >= {1'b0, MOD}) u = u - {1'b0, MOD};
    return u[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] w_mont;

  assign w_mont = redc({{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b});
  assign o_p    = redc({{WIDTH{1'b0}}, w_mont} * {{WIDTH{1'b0}}, R2MOD});

endmodule

// File: rtl/mod_exp.sv
// rtl/mod_exp.sv - right-to-left square-and-multiply base^exponent mod MOD, one bit per clock
// MOD_EXP_CONST_TIME_EN: always run EXP_W iterations for exponent-independent latency.
module mod_exp
  import mod_arith_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter logic [WIDTH-1:0] MOD    = WIDTH'(MOD_DEFAULT),
  parameter logic [WIDTH-1:0] NPRIME = WIDTH'(NPRIME_DEFAULT),
  parameter logic [WIDTH-1:0] R2MOD  = WIDTH'(R2MOD_DEFAULT),
  parameter int unsigned EXP_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [EXP_W-1:0] exponent,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  exp_state_t       r_state;
  logic             r_ready;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_base;
  logic [EXP_W-1:0] r_exp;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [EXP_W-1:0] r_e;

`ifdef MOD_EXP_CONST_TIME_EN
  localparam int unsigned CNT_W = $clog2(EXP_W + 1);
  logic [CNT_W-1:0] r_cnt;
`endif

  logic [WIDTH-1:0] w_sq_a;
  logic [WIDTH-1:0] w_sq_b;
  logic [WIDTH-1:0] w_sq_p;
  logic [WIDTH-1:0] w_acc_p;

  // LOAD borrows the squarer to reduce the raw base: base*1 mod MOD.
  assign w_sq_a = (r_state == LOAD) ? r_base : r_b;
  assign w_sq_b = (r_state == LOAD) ? WIDTH'(1) : r_b;

  mod_mul #(.WIDTH(WIDTH), .MOD(MOD), .NPRIME(NPRIME), .R2MOD(R2MOD)) u_mul_sq (
    .i_a (w_sq_a),
    .i_b (w_sq_b),
    .o_p (w_sq_p)
  );

  mod_mul #(.WIDTH(WIDTH), .MOD(MOD), .NPRIME(NPRIME), .R2MOD(R2MOD)) u_mul_acc (
    .i_a (r_acc),
    .i_b (r_b),
    .o_p (w_acc_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_result <= '0;
      r_base   <= '0;
      r_exp    <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_e      <= '0;
`ifdef MOD_EXP_CONST_TIME_EN
      r_cnt    <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_base  <= base;
            r_exp   <= exponent;
            r_ready <= 1'b0;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_b     <= w_sq_p;
          r_e     <= r_exp;
          r_acc   <= WIDTH'(1);
`ifdef MOD_EXP_CONST_TIME_EN
          r_cnt   <= '0;
`endif
          r_state <= RUN;
        end
        RUN: begin
`ifdef MOD_EXP_CONST_TIME_EN
          if (r_cnt == CNT_W'(EXP_W)) begin
`else
          if (r_e == '0) begin
`endif
            r_result <= r_acc;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end else begin
            if (r_e[0]) r_acc <= w_acc_p;
            r_b <= w_sq_p;
            r_e <= r_e >> 1;
`ifdef MOD_EXP_CONST_TIME_EN
            r_cnt <= r_cnt + CNT_W'(1);
`endif
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready  = r_ready;
  assign done   = r_done;
  assign result = r_result;

endmodule
